// File: rtl/fx_bus_bridge_if.sv
// Command-side and fx-bus signal bundle for fx_bus_bridge.
// The master modport is the bridge's own view; slave is the environment's view.
interface fx_bus_bridge_if #(
   parameter int unsigned MOD_W  = 6,
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned FXA_W = 2 + MOD_W + ADDR_W;

   logic [MOD_W+1:0]  i_cmdl_mod;
   logic [ADDR_W-1:0] i_cmdl_addr;
   logic [DATA_W-1:0] i_cmdl_data;
   logic              i_cmdl_vld;
   logic              o_cmdl_rdy;
   logic              o_cmd_err;
   logic [DATA_W-1:0] o_cmdl_q;
   logic              o_cmdl_q_vld;
   logic [FXA_W-1:0]  o_fx_waddr;
   logic              o_fx_wr;
   logic [DATA_W-1:0] o_fx_data;
   logic              o_fx_rd;
   logic [FXA_W-1:0]  o_fx_raddr;
   logic [DATA_W-1:0] i_fx_q;

   modport master (
      input  i_cmdl_mod, i_cmdl_addr, i_cmdl_data, i_cmdl_vld, i_fx_q,
      output o_cmdl_rdy, o_cmd_err, o_cmdl_q, o_cmdl_q_vld,
      output o_fx_waddr, o_fx_wr, o_fx_data, o_fx_rd, o_fx_raddr
   );

   modport slave (
      output i_cmdl_mod, i_cmdl_addr, i_cmdl_data, i_cmdl_vld, i_fx_q,
      input  o_cmdl_rdy, o_cmd_err, o_cmdl_q, o_cmdl_q_vld,
      input  o_fx_waddr, o_fx_wr, o_fx_data, o_fx_rd, o_fx_raddr
   );
endinterface

// File: rtl/fx_bus_bridge.sv
// Command-line to fx register bus bridge: command FIFO feeding a one-command-at-a-time
// strobe issuer, with fixed-latency read return.
module fx_bus_bridge #(
   parameter int unsigned MOD_W      = 6,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned RD_LAT     = 1
) (
   input  logic             clk_sys,
   input  logic             rst_n,
   fx_bus_bridge_if.master  io_bus
);
   localparam int unsigned FXA_W = 2 + MOD_W + ADDR_W;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned ENT_W = 1 + MOD_W + ADDR_W + DATA_W;
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StIssueWr, StIssueRd, StRdWait} state_e;

   logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  r_wptr, r_rptr;
   logic [PTR_W:0]    r_count;
   logic              r_rdy, r_cmd_err;
   state_e            r_state;
   logic [3:0]        r_cnt;
   logic              r_fx_wr, r_fx_rd;
   logic [FXA_W-1:0]  r_fx_addr;
   logic [DATA_W-1:0] r_fx_data, r_q;
   logic              r_q_vld;

   logic [1:0]        w_op;
   logic              w_legal, w_push, w_pop, w_empty, w_head_wr;
   logic [ENT_W-1:0]  w_head;
   logic [PTR_W:0]    w_count_d;
   state_e            w_state_d;
   logic              w_fx_wr_d, w_fx_rd_d, w_q_vld_d;
   logic [FXA_W-1:0]  w_fx_addr_d;
   logic [DATA_W-1:0] w_fx_data_d, w_q_d;
   logic [3:0]        w_cnt_d;

   assign w_op      = io_bus.i_cmdl_mod[MOD_W+1:MOD_W];
   assign w_legal   = (w_op == 2'b10) || (w_op == 2'b00);
   assign w_push    = io_bus.i_cmdl_vld & r_rdy & w_legal;
   assign w_empty   = (r_count == '0);
   assign w_head    = r_mem[r_rptr];
   assign w_head_wr = w_head[ENT_W-1];
   assign w_count_d = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};

   // Entry layout: {is_write, mod_id, addr, data}
   always_ff @(posedge clk_sys) begin
      if (w_push) begin
         r_mem[r_wptr] <= {w_op[1], io_bus.i_cmdl_mod[MOD_W-1:0], io_bus.i_cmdl_addr,
                           io_bus.i_cmdl_data};
      end
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_rdy     <= 1'b1;
         r_cmd_err <= 1'b0;
         r_state   <= StIdle;
         r_cnt     <= '0;
         r_fx_wr   <= 1'b0;
         r_fx_rd   <= 1'b0;
         r_fx_addr <= '0;
         r_fx_data <= '0;
         r_q       <= '0;
         r_q_vld   <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         r_count   <= w_count_d;
         r_rdy     <= (w_count_d != FULL_CNT);
         r_cmd_err <= io_bus.i_cmdl_vld & (~w_legal | ~r_rdy);
         r_state   <= w_state_d;
         r_cnt     <= w_cnt_d;
         r_fx_wr   <= w_fx_wr_d;
         r_fx_rd   <= w_fx_rd_d;
         r_fx_addr <= w_fx_addr_d;
         r_fx_data <= w_fx_data_d;
         r_q       <= w_q_d;
         r_q_vld   <= w_q_vld_d;
      end
   end

   always_comb begin
      w_state_d = r_state;
      w_pop     = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (!w_empty) begin
               w_pop     = 1'b1;
               w_state_d = w_head_wr ? StIssueWr : StIssueRd;
            end
         end
         StIssueWr: begin
            if (!w_empty && w_head_wr) w_pop = 1'b1;
            else                       w_state_d = StIdle;
         end
         StIssueRd: w_state_d = StRdWait;
         StRdWait:  if (r_cnt == '0) w_state_d = StIdle;
         default:   w_state_d = StIdle;
      endcase
   end

   always_comb begin
      w_fx_wr_d   = w_pop & w_head_wr;
      w_fx_rd_d   = w_pop & ~w_head_wr;
      w_fx_addr_d = w_pop ? {2'b00, w_head[DATA_W+ADDR_W +: MOD_W], w_head[DATA_W +: ADDR_W]}
                          : '0;
      w_fx_data_d = (w_pop & w_head_wr) ? w_head[DATA_W-1:0] : '0;
      w_cnt_d     = r_cnt;
      w_q_vld_d   = 1'b0;
      w_q_d       = r_q;
      if (r_state == StIssueRd) begin
         w_cnt_d = 4'(RD_LAT - 1);
      end else if (r_state == StRdWait) begin
         if (r_cnt == '0) begin
            w_q_vld_d = 1'b1;
            w_q_d     = io_bus.i_fx_q;
         end else begin
            w_cnt_d = r_cnt - 4'd1;
         end
      end
   end

   assign io_bus.o_cmdl_rdy   = r_rdy;
   assign io_bus.o_cmd_err    = r_cmd_err;
   assign io_bus.o_cmdl_q     = r_q;
   assign io_bus.o_cmdl_q_vld = r_q_vld;
   assign io_bus.o_fx_wr      = r_fx_wr;
   assign io_bus.o_fx_rd      = r_fx_rd;
   assign io_bus.o_fx_waddr   = r_fx_wr ? r_fx_addr : '0;
   assign io_bus.o_fx_raddr   = r_fx_rd ? r_fx_addr : '0;
   assign io_bus.o_fx_data    = r_fx_data;
endmodule

// File: tb/tb_fx_bus_bridge.sv
// Randomised scoreboard bench for fx_bus_bridge: a transaction-level model predicts the fx
// strobe sequence, read returns, FIFO readiness and error pulses.
module tb_fx_bus_bridge;
   localparam int unsigned RD_LAT = 3;
   localparam int unsigned DEPTH  = 4;

   typedef struct {
      bit         wr;
      logic [15:0] addr;
      logic [7:0]  data;
   } fx_t;

   logic clk_sys = 1'b0;
   logic rst_n   = 1'b0;
   int   n_checks = 0;
   int   n_pass   = 0;

   fx_bus_bridge_if #(.MOD_W(6), .ADDR_W(8), .DATA_W(8)) bus ();

   fx_bus_bridge #(
      .MOD_W(6), .ADDR_W(8), .DATA_W(8), .FIFO_DEPTH(DEPTH), .RD_LAT(RD_LAT)
   ) dut (
      .clk_sys(clk_sys),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Model state, owned by the monitor process.
   fx_t        exp_fx[$];
   logic [7:0] exp_q[$];
   int         occ;
   bit         push_pend, prev_vld, prev_legal, prev_rdy;
   bit         rd_active;
   int         rd_k;
   logic [7:0] rd_data, last_q;

   function automatic bit legal_op(input logic [7:0] m);
      return (m[7:6] == 2'b10) || (m[7:6] == 2'b00);
   endfunction

   always @(negedge clk_sys) begin
      if (!rst_n) begin
         exp_fx.delete();
         exp_q.delete();
         occ = 0; push_pend = 0; prev_vld = 0; prev_legal = 0; prev_rdy = 1;
         rd_active = 0; rd_k = 0; last_q = '0;
         bus.i_fx_q = 8'($urandom);
      end else begin
         if (push_pend) occ++;
         check("cmd_err", bus.o_cmd_err, prev_vld && (!prev_legal || !prev_rdy));
         check("strobe_excl", bus.o_fx_wr & bus.o_fx_rd, 1'b0);
         // Read slave: data is correct only in the RD_LAT-th cycle after the strobe cycle.
         if (rd_active) begin
            rd_k++;
            bus.i_fx_q = (rd_k == RD_LAT) ? rd_data
                                          : rd_data ^ 8'($urandom_range(1, 255));
            if (rd_k == RD_LAT) rd_active = 0;
         end
         if (bus.o_fx_wr || bus.o_fx_rd) begin
            occ--;
            if (exp_fx.size() == 0) begin
               check("unexpected_strobe", {bus.o_fx_wr, bus.o_fx_rd}, 2'b00);
            end else begin
               fx_t e;
               e = exp_fx.pop_front();
               check("strobe_kind", {bus.o_fx_wr, bus.o_fx_rd}, {e.wr, !e.wr});
               check("fx_bus", {bus.o_fx_waddr, bus.o_fx_raddr, bus.o_fx_data},
                     e.wr ? {e.addr, 16'h0, e.data} : {16'h0, e.addr, 8'h0});
            end
            if (bus.o_fx_rd) begin
               rd_active  = 1;
               rd_k       = 0;
               rd_data    = 8'($urandom);
               bus.i_fx_q = ~rd_data;
               exp_q.push_back(rd_data);
            end
         end else begin
            check("fx_idle_zero", {bus.o_fx_waddr, bus.o_fx_raddr, bus.o_fx_data}, 40'h0);
         end
         if (bus.o_cmdl_q_vld) begin
            if (exp_q.size() == 0) begin
               check("unexpected_q_vld", bus.o_cmdl_q_vld, 1'b0);
            end else begin
               last_q = exp_q.pop_front();
               check("cmdl_q", bus.o_cmdl_q, last_q);
            end
         end else begin
            check("cmdl_q_hold", bus.o_cmdl_q, last_q);
         end
         check("cmdl_rdy", bus.o_cmdl_rdy, occ != DEPTH);
         prev_vld   = bus.i_cmdl_vld;
         prev_legal = legal_op(bus.i_cmdl_mod);
         prev_rdy   = (occ != DEPTH);
         push_pend  = prev_vld && prev_legal && prev_rdy;
         if (push_pend) begin
            fx_t n;
            n.wr   = bus.i_cmdl_mod[7];
            n.addr = {2'b00, bus.i_cmdl_mod[5:0], bus.i_cmdl_addr};
            n.data = bus.i_cmdl_data;
            exp_fx.push_back(n);
         end
      end
   end

   task automatic cmd(input logic [7:0] m, input logic [7:0] a, input logic [7:0] d);
      @(posedge clk_sys);
      #1;
      bus.i_cmdl_vld  = 1'b1;
      bus.i_cmdl_mod  = m;
      bus.i_cmdl_addr = a;
      bus.i_cmdl_data = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk_sys);
         #1;
         bus.i_cmdl_vld  = 1'b0;
         bus.i_cmdl_mod  = 8'($urandom);
         bus.i_cmdl_addr = 8'($urandom);
         bus.i_cmdl_data = 8'($urandom);
      end
   endtask

   task automatic check_reset_outs(input string name);
      check(name, {bus.o_cmdl_rdy, bus.o_cmd_err, bus.o_cmdl_q, bus.o_cmdl_q_vld,
                   bus.o_fx_waddr, bus.o_fx_wr, bus.o_fx_data, bus.o_fx_rd, bus.o_fx_raddr},
            {1'b1, 52'h0});
   endtask

   initial begin
      bus.i_cmdl_vld  = 1'b0;
      bus.i_cmdl_mod  = '0;
      bus.i_cmdl_addr = '0;
      bus.i_cmdl_data = '0;
      @(negedge clk_sys);
      check_reset_outs("reset_state");
      repeat (2) @(posedge clk_sys);
      #1 rst_n = 1'b1;
      idle(2);

      // Single write: strobe appears in the cycle after the second edge.
      cmd(8'h85, 8'h12, 8'hA5);
      idle(1);
      @(negedge clk_sys);
      check("t1_not_early", bus.o_fx_wr, 1'b0);
      @(negedge clk_sys);
      check("t1_write", {bus.o_fx_waddr, bus.o_fx_data, bus.o_fx_wr, bus.o_fx_rd},
            {16'h0512, 8'hA5, 1'b1, 1'b0});
      @(negedge clk_sys);
      check("t1_one_cycle", bus.o_fx_wr, 1'b0);
      idle(3);

      // Back-to-back writes.
      cmd(8'h81, 8'h01, 8'h11);
      cmd(8'h82, 8'h02, 8'h22);
      cmd(8'h83, 8'h03, 8'h33);
      idle(8);

      // Single read.
      cmd(8'h03, 8'h40, 8'h00);
      idle(12);

      // Fill while a read is outstanding, then overflow twice.
      cmd(8'h04, 8'h10, 8'h00);
      for (int i = 0; i < 6; i++) cmd(8'h90 + 8'(i), 8'(i), 8'hC0 + 8'(i));
      idle(30);

      // Illegal ops.
      cmd(8'hC1, 8'h55, 8'h66);
      cmd(8'h41, 8'h77, 8'h88);
      idle(6);

      // Reset during read wait with two queued writes.
      cmd(8'h03, 8'h40, 8'h00);
      cmd(8'h85, 8'h20, 8'h01);
      cmd(8'h86, 8'h21, 8'h02);
      idle(2);
      rst_n = 1'b0;
      @(negedge clk_sys);
      check_reset_outs("reset_mid_read");
      repeat (2) @(posedge clk_sys);
      #1 rst_n = 1'b1;
      idle(20);

      // Randomised traffic, mostly legal ops.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            logic [1:0] op;
            int unsigned pick;
            pick = $urandom_range(0, 9);
            op = (pick < 5) ? 2'b10 : (pick < 8) ? 2'b00 : (pick == 8) ? 2'b01 : 2'b11;
            cmd({op, 6'($urandom)}, 8'($urandom), 8'($urandom));
         end else begin
            idle(1);
         end
      end
      idle(60);

      check("drain_fx", 32'(exp_fx.size()), 32'd0);
      check("drain_q", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
